// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parity-protected FIFO pop path.
package fifo_pkg;

    // Widest payload the helpers handle; callers zero-extend their word to MAX_W+1 bits.
    localparam int MAX_W = 128;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } chk_state_e;

    // Zero-extension does not change the XOR, so the full-width reduction is exact.
    function automatic logic parity_ok(input logic [MAX_W:0] word, input logic even_odd);
        return (^word) == even_odd;
    endfunction

    // parity_bit = 0: parity at the MSB, payload below it (caller truncates).
    // parity_bit = 1: parity at bit 0, payload above it.
    function automatic logic [MAX_W-1:0] payload_extract(input logic [MAX_W:0] word,
                                                          input logic       parity_bit);
        return parity_bit ? word[MAX_W:1] : word[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order valid/ready buffer. Head entry drives the read side.
module skid_buf2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             rd_ready_i,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             wr, rd;

    assign rd = (count_q != 2'd0) && rd_ready_i;
    assign wr = wr_valid_i && ((count_q != 2'd2) || rd);

    // Next-state of the two entries and occupancy; pop shifts tail into head.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({wr, rd})
            2'b10: begin
                if (count_q == 2'd0) head_d = wr_data_i;
                else                 tail_d = wr_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = wr_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = wr_data_i;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = head_q;
    assign count_o    = count_q;

endmodule

// File: rtl/pop_parity_checker.sv
// Parity checker on the FIFO pop port: strips parity from good words into a
// 2-entry output buffer, drops and counts corrupt words, optionally halts.
//
// state | meaning
// RUN   | granting words whenever the output buffer has room
// HALT  | corrupt word seen with ERR_MODE=1; no grant until resume_i
module pop_parity_checker
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0,
    parameter int ERR_MODE   = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   pop_data_i,
    input  logic                  pop_valid_i,
    output logic                  pop_grant_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  err_pulse_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    input  logic                  clear_cnt_i,
    input  logic                  resume_i,
    output logic                  halted_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    chk_state_e            state_q, state_d;
    logic [MAX_W:0]        word_ext;
    logic [DATA_WIDTH-1:0] payload;
    logic                  word_ok;
    logic                  xfer;
    logic                  bad_xfer;
    logic [1:0]            buf_count;
    logic                  err_pulse_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign word_ext = {{(MAX_W-DATA_WIDTH){1'b0}}, pop_data_i};
    assign word_ok  = parity_ok(word_ext, EVEN_ODD != 0);
    assign payload  = DATA_WIDTH'(payload_extract(word_ext, PARITY_BIT != 0));

    // Grant comes only from registered state so it never loops back on pop_valid_i.
    assign pop_grant_o = (state_q == RUN) && (buf_count != 2'd2);
    assign xfer        = pop_valid_i && pop_grant_o;
    assign bad_xfer    = xfer && !word_ok;

    skid_buf2 #(
        .WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_valid_i(xfer && word_ok),
        .wr_data_i (payload),
        .rd_valid_o(out_valid_o),
        .rd_data_o (out_data_o),
        .rd_ready_i(out_ready_i),
        .count_o   (buf_count)
    );

    // Next-state: corrupt word halts only when ERR_MODE=1; resume is ignored in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bad_xfer && (ERR_MODE != 0)) state_d = HALT;
            HALT:    if (resume_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Saturating error counter; a clear coinciding with a drop leaves that drop counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt_i)
            cnt_d = bad_xfer ? CNT_WIDTH'(1) : '0;
        else if (bad_xfer && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // State, error pulse and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            err_pulse_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            err_pulse_q <= bad_xfer;
            cnt_q       <= cnt_d;
        end
    end

    assign err_pulse_o = err_pulse_q;
    assign err_count_o = cnt_q;
    assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_pop_parity_checker.sv
// Bench for pop_parity_checker: unit 0 uses defaults, unit 1 uses ERR_MODE=1, CNT_WIDTH=2.
module tb_pop_parity_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_rst[2];
    logic        pv[2];
    logic [32:0] pd[2];
    logic        rdy[2];
    logic        clr[2];
    logic        res[2];
    logic        gr[2];
    logic        ov[2];
    logic        ep[2];
    logic        hl[2];
    logic [31:0] od[2];
    logic [7:0]  ec0;
    logic [1:0]  ec1;
    logic [7:0]  ecv[2];

    assign ecv[0] = ec0;
    assign ecv[1] = {6'b0, ec1};

    pop_parity_checker u0 (
        .clk(clk), .rst(t_rst[0]), .pop_data_i(pd[0]), .pop_valid_i(pv[0]),
        .pop_grant_o(gr[0]), .out_data_o(od[0]), .out_valid_o(ov[0]),
        .out_ready_i(rdy[0]), .err_pulse_o(ep[0]), .err_count_o(ec0),
        .clear_cnt_i(clr[0]), .resume_i(res[0]), .halted_o(hl[0])
    );

    pop_parity_checker #(.ERR_MODE(1), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst(t_rst[1]), .pop_data_i(pd[1]), .pop_valid_i(pv[1]),
        .pop_grant_o(gr[1]), .out_data_o(od[1]), .out_valid_o(ov[1]),
        .out_ready_i(rdy[1]), .err_pulse_o(ep[1]), .err_count_o(ec1),
        .clear_cnt_i(clr[1]), .resume_i(res[1]), .halted_o(hl[1])
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a queue of accepted payloads per unit plus halt flag and counter.
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    logic        m_halt[2];
    logic        m_pulse[2];
    int          m_cnt[2];

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [31:0] qhead(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: predict from the rules, advance the model, then check both units.
    task automatic cyc();
        logic        xf[2];
        logic        okw[2];
        logic        popm[2];
        logic [31:0] pl[2];
        for (int k = 0; k < 2; k++) begin
            xf[k]   = pv[k] && !m_halt[k] && (qsize(k) < 2);
            okw[k]  = ((^pd[k]) == 1'b0);
            popm[k] = (qsize(k) > 0) && rdy[k];
            pl[k]   = pd[k][31:0];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (t_rst[k]) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                m_halt[k]  = 1'b0;
                m_pulse[k] = 1'b0;
                m_cnt[k]   = 0;
            end else begin
                if (popm[k]) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (xf[k] && okw[k]) begin
                    if (k == 0) mq0.push_back(pl[k]); else mq1.push_back(pl[k]);
                end
                m_pulse[k] = xf[k] && !okw[k];
                if (clr[k])          m_cnt[k] = m_pulse[k] ? 1 : 0;
                else if (m_pulse[k]) m_cnt[k] = (m_cnt[k] + 1 > cmax(k)) ? cmax(k) : m_cnt[k] + 1;
                if (m_pulse[k] && k == 1)  m_halt[k] = 1'b1;
                else if (m_halt[k] && res[k]) m_halt[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_grant", k), 32'(gr[k]), 32'(!m_halt[k] && qsize(k) < 2));
            chk($sformatf("u%0d_valid", k), 32'(ov[k]), 32'(qsize(k) > 0));
            if (qsize(k) > 0) chk($sformatf("u%0d_data", k), od[k], qhead(k));
            chk($sformatf("u%0d_pulse", k), 32'(ep[k]), 32'(m_pulse[k]));
            chk($sformatf("u%0d_count", k), 32'(ecv[k]), 32'(m_cnt[k]));
            chk($sformatf("u%0d_halted", k), 32'(hl[k]), 32'(m_halt[k]));
        end
    endtask

    typedef struct packed {
        logic        v;
        logic [32:0] d;
        logic        r;
        logic        gr;
        logic        ov;
        logic [31:0] od;
        logic        ep;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // good stream
        tbl[0]  = '{1'b1, {1'b0, 32'h3}, 1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, {1'b1, 32'h1}, 1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, {1'b0, 32'hF}, 1'b1, 1'b1, 1'b1, 32'hF, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 33'h0,         1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'd0};
        // corrupt drop between 0x2 and 0x4
        tbl[4]  = '{1'b1, {1'b1, 32'h2}, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, {1'b0, 32'h1}, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 8'd1};
        tbl[6]  = '{1'b1, {1'b1, 32'h4}, 1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 33'h0,         1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'd1};
        // backpressure: four words offered, two taken, rest follow in order
        tbl[8]  = '{1'b1, {1'b0, 32'h3}, 1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, {1'b1, 32'h1}, 1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 8'd1};
        tbl[10] = '{1'b1, {1'b0, 32'hF}, 1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 8'd1};
        tbl[11] = '{1'b1, {1'b0, 32'hF}, 1'b0, 1'b0, 1'b1, 32'h3, 1'b0, 8'd1};
        tbl[12] = '{1'b1, {1'b0, 32'hF}, 1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 8'd1};
        tbl[13] = '{1'b1, {1'b0, 32'hF}, 1'b1, 1'b1, 1'b1, 32'hF, 1'b0, 8'd1};
        tbl[14] = '{1'b1, {1'b1, 32'h2}, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 8'd1};
        tbl[15] = '{1'b0, 33'h0,         1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 8'd1};

        for (int k = 0; k < 2; k++) begin
            t_rst[k] = 1'b1; pv[k] = 1'b0; pd[k] = '0; rdy[k] = 1'b1;
            clr[k] = 1'b0; res[k] = 1'b0;
            m_halt[k] = 1'b0; m_pulse[k] = 1'b0; m_cnt[k] = 0;
        end

        // reset then idle
        cyc();
        cyc();
        t_rst[0] = 1'b0; t_rst[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_u%0d_grant", k), 32'(gr[k]), 32'd1);
            chk($sformatf("rst_u%0d_valid", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_u%0d_data", k), od[k], 32'd0);
            chk($sformatf("rst_u%0d_count", k), 32'(ecv[k]), 32'd0);
            chk($sformatf("rst_u%0d_halted", k), 32'(hl[k]), 32'd0);
        end

        // table vectors on unit 0
        for (int i = 0; i < 16; i++) begin
            pv[0] = tbl[i].v; pd[0] = tbl[i].d; rdy[0] = tbl[i].r;
            cyc();
            chk($sformatf("tbl%0d_grant", i), 32'(gr[0]), 32'(tbl[i].gr));
            chk($sformatf("tbl%0d_valid", i), 32'(ov[0]), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), od[0], tbl[i].od);
            chk($sformatf("tbl%0d_pulse", i), 32'(ep[0]), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_count", i), 32'(ec0), 32'(tbl[i].cnt));
        end

        // halt / resume on unit 1
        pv[1] = 1'b1; pd[1] = {1'b0, 32'h1};
        cyc();
        chk("halt_enter", 32'(hl[1]), 32'd1);
        chk("halt_grant", 32'(gr[1]), 32'd0);
        chk("halt_pulse", 32'(ep[1]), 32'd1);
        pd[1] = {1'b0, 32'h3};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_hold_grant", 32'(gr[1]), 32'd0);
            chk("halt_hold_valid", 32'(ov[1]), 32'd0);
        end
        res[1] = 1'b1;
        cyc();
        res[1] = 1'b0;
        chk("resume_halted", 32'(hl[1]), 32'd0);
        chk("resume_grant", 32'(gr[1]), 32'd1);
        cyc();
        chk("resume_pass_valid", 32'(ov[1]), 32'd1);
        chk("resume_pass_data", od[1], 32'h3);
        pv[1] = 1'b0;
        cyc();

        // counter saturation at 3 on unit 1
        t_rst[1] = 1'b1;
        cyc();
        t_rst[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pv[1] = 1'b1; pd[1] = {1'b0, 32'h1};
            cyc();
            chk($sformatf("sat%0d_count", i), 32'(ec1), (i < 2) ? 32'(i + 1) : 32'd3);
            pv[1] = 1'b0; res[1] = 1'b1;
            cyc();
            res[1] = 1'b0;
        end
        pv[1] = 1'b1; pd[1] = {1'b0, 32'h1}; clr[1] = 1'b1;
        cyc();
        chk("clr_with_err", 32'(ec1), 32'd1);
        pv[1] = 1'b0; res[1] = 1'b1;
        cyc();
        chk("clr_alone", 32'(ec1), 32'd0);
        clr[1] = 1'b0; res[1] = 1'b0;

        // reset mid-operation on unit 0 with a word in flight
        rdy[0] = 1'b0; pv[0] = 1'b1; pd[0] = {1'b0, 32'h3};
        cyc();
        cyc();
        t_rst[0] = 1'b1; pd[0] = {1'b0, 32'h5};
        cyc();
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_grant", 32'(gr[0]), 32'd1);
        chk("midrst_count", 32'(ec0), 32'd0);
        t_rst[0] = 1'b0; pv[0] = 1'b0;
        cyc();
        chk("midrst_not_taken", 32'(ov[0]), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] p;
                logic        bad;
                p        = $urandom;
                bad      = ($urandom_range(0, 3) == 0);
                pd[k]    = {(^p) ^ bad, p};
                pv[k]    = ($urandom_range(0, 3) != 0);
                rdy[k]   = ($urandom_range(0, 4) < 3);
                clr[k]   = ($urandom_range(0, 29) == 0);
                res[k]   = ($urandom_range(0, 9) == 0);
                t_rst[k] = ($urandom_range(0, 99) == 0);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
